// File: rtl/range_slice_streamer_pkg.sv
// Shared definitions for the range-slice streamer: mode encodings, FSM state
// type and helpers that derive the normalised bit range of a declared word.
package slice_pkg;

  localparam int SLICE_ASC  = 0;
  localparam int SLICE_DESC = 1;

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  function automatic int range_lo(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int range_hi(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Fragment counter width; a single-fragment word still needs one bit.
  function automatic int idx_width(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/range_slice_streamer_slice_select.sv
// Combinational fragment selector: picks fragment idx of a word declared
// [LEFT:RIGHT], using +: from LO (ascending) or -: from HI (descending).
module slice_select
  import slice_pkg::*;
#(
  parameter  int LEFT   = 0,
  parameter  int RIGHT  = 7,
  parameter  int SLICE  = 2,
  parameter  int MODE   = SLICE_ASC,
  localparam int LO     = range_lo(LEFT, RIGHT),
  localparam int HI     = range_hi(LEFT, RIGHT),
  localparam int LEN    = HI - LO + 1,
  localparam int NSLICE = (SLICE > 0) ? (LEN / SLICE) : 1,
  localparam int IW     = idx_width(NSLICE)
) (
  input  logic [LEFT:RIGHT]  word,
  input  logic [IW-1:0]      idx,
  output logic [SLICE-1:0]   data
);

  // Every fragment is a constant part-select, so the offset LO+g*SLICE is
  // resolved at elaboration and can never wrap or leave [LO:HI].
  logic [SLICE-1:0] frag [NSLICE];

  for (genvar g = 0; g < NSLICE; g++) begin : g_frag
    if (MODE == SLICE_DESC) begin : g_desc
      assign frag[g] = word[HI - g*SLICE -: SLICE];
    end else begin : g_asc
      assign frag[g] = word[LO + g*SLICE +: SLICE];
    end
  end

  // Index-driven mux over the precomputed fragments.
  always_comb begin
    data = '0;
    for (int unsigned i = 0; i < NSLICE; i++) begin
      if (idx == IW'(i)) data = frag[i];
    end
  end

endmodule

// File: rtl/range_slice_streamer.sv
// Captures one [LEFT:RIGHT] word and streams it as SLICE-wide fragments over
// a valid/ready link, reloading back-to-back on the last fragment.
module range_slice_streamer
  import slice_pkg::*;
#(
  parameter  int LEFT   = 0,
  parameter  int RIGHT  = 7,
  parameter  int SLICE  = 2,
  parameter  int MODE   = SLICE_ASC,
  localparam int LO     = range_lo(LEFT, RIGHT),
  localparam int HI     = range_hi(LEFT, RIGHT),
  localparam int LEN    = HI - LO + 1,
  localparam int NSLICE = (SLICE > 0) ? (LEN / SLICE) : 1,
  localparam int IW     = idx_width(NSLICE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LEFT:RIGHT] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SLICE-1:0]  out_data,
  output logic [IW-1:0]     out_index,
  output logic              out_last
);

  if (SLICE < 1) begin : g_bad_slice
    $error("range_slice_streamer: SLICE must be at least 1");
  end else if ((LEN % SLICE) != 0) begin : g_bad_len
    $error("range_slice_streamer: word length must be a multiple of SLICE");
  end

  state_t            state, state_n;
  logic [IW-1:0]     idx, idx_n;
  logic [LEFT:RIGHT] cap, cap_n;
  logic              load;

  assign out_valid = (state == STREAM);
  assign out_index = idx;
  assign out_last  = out_valid && (idx == IW'(NSLICE - 1));

  // State, fragment counter and capture register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      cap   <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      cap   <= cap_n;
    end
  end

  // Next state: accept in IDLE or on the consumed last fragment, else advance.
  always_comb begin
    state_n  = state;
    idx_n    = idx;
    cap_n    = cap;
    in_ready = 1'b0;
    load     = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        load     = in_valid;
      end
      STREAM: begin
        if (out_ready) begin
          if (out_last) begin
            in_ready = 1'b1;
            load     = in_valid;
            if (!in_valid) begin
              state_n = IDLE;
              idx_n   = '0;
            end
          end else begin
            idx_n = idx + IW'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
    if (load) begin
      state_n = STREAM;
      idx_n   = '0;
      cap_n   = in_data;
    end
  end

  slice_select #(
    .LEFT (LEFT),
    .RIGHT(RIGHT),
    .SLICE(SLICE),
    .MODE (MODE)
  ) u_select (
    .word(cap),
    .idx (idx),
    .data(out_data)
  );

endmodule

// File: tb/tb_range_slice_streamer.sv
module tb_range_slice_streamer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Shared stimulus for the three 8-bit two-bit-slice instances.
  logic       iv = 1'b0, rdy = 1'b0;
  logic [7:0] d1 = '0, d2 = '0;
  logic [0:7] d3 = '0;
  logic       ir1, ir2, ir3, ov1, ov2, ov3, ol1, ol2, ol3;
  logic [1:0] od1, od2, od3, oi1, oi2, oi3;

  // Instance 4: [11:4], SLICE=4.  Instance 5: [3:0], SLICE=4 (one fragment).
  logic        iv4 = 1'b0, rdy4 = 1'b0, iv5 = 1'b0, rdy5 = 1'b0;
  logic [11:4] d4 = '0;
  logic [3:0]  d5 = '0;
  logic        ir4, ov4, ol4, ir5, ov5, ol5;
  logic [3:0]  od4, od5;
  logic [0:0]  oi4, oi5;

  range_slice_streamer #(.LEFT(7), .RIGHT(0), .SLICE(2), .MODE(0)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir1), .in_data(d1),
    .out_valid(ov1), .out_ready(rdy), .out_data(od1), .out_index(oi1), .out_last(ol1));
  range_slice_streamer #(.LEFT(7), .RIGHT(0), .SLICE(2), .MODE(1)) u2 (
    .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir2), .in_data(d2),
    .out_valid(ov2), .out_ready(rdy), .out_data(od2), .out_index(oi2), .out_last(ol2));
  range_slice_streamer #(.LEFT(0), .RIGHT(7), .SLICE(2), .MODE(0)) u3 (
    .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir3), .in_data(d3),
    .out_valid(ov3), .out_ready(rdy), .out_data(od3), .out_index(oi3), .out_last(ol3));
  range_slice_streamer #(.LEFT(11), .RIGHT(4), .SLICE(4), .MODE(0)) u4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .in_data(d4),
    .out_valid(ov4), .out_ready(rdy4), .out_data(od4), .out_index(oi4), .out_last(ol4));
  range_slice_streamer #(.LEFT(3), .RIGHT(0), .SLICE(4), .MODE(0)) u5 (
    .clk(clk), .rst(rst), .in_valid(iv5), .in_ready(ir5), .in_data(d5),
    .out_valid(ov5), .out_ready(rdy5), .out_data(od5), .out_index(oi5), .out_last(ol5));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks one fragment on each of u1..u3 (fragment k of 0xB4).
  task automatic chk123(input string tag, input int k, input logic last);
    logic [1:0] e1 [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
    logic [1:0] e2 [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
    chk({tag, " u1 valid"}, 32'(ov1), 32'd1);
    chk({tag, " u1 data"},  32'(od1), 32'(e1[k]));
    chk({tag, " u1 index"}, 32'(oi1), 32'(k));
    chk({tag, " u1 last"},  32'(ol1), 32'(last));
    chk({tag, " u2 data"},  32'(od2), 32'(e2[k]));
    chk({tag, " u2 last"},  32'(ol2), 32'(last));
    chk({tag, " u3 data"},  32'(od3), 32'(e2[k]));
    chk({tag, " u3 index"}, 32'(oi3), 32'(k));
  endtask

  initial begin
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst valid", 32'(ov1), 32'd0);
    chk("rst index", 32'(oi1), 32'd0);
    chk("rst last",  32'(ol1), 32'd0);
    chk("rst data",  32'(od1), 32'd0);
    chk("rst ready", 32'(ir1), 32'd1);
    chk("rst ready u4", 32'(ir4), 32'd1);

    // Tests 1-3: full-rate stream of 0xB4 through u1..u3
    d1 = 8'hB4; d2 = 8'hB4; d3 = 8'hB4;
    iv = 1'b1; rdy = 1'b1;
    tick();
    iv = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk123("t123", k, k == 3);
      chk("t123 in_ready", 32'(ir1), 32'(k == 3));
      tick();
    end
    chk("t123 idle valid", 32'(ov1), 32'd0);
    chk("t123 idle ready", 32'(ir3), 32'd1);

    // Test 5: backpressure on fragment 1
    iv = 1'b1;
    tick();
    iv = 1'b0;
    chk123("t5 f0", 0, 1'b0);
    tick();
    rdy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk123("t5 hold", 1, 1'b0);
      chk("t5 hold ready", 32'(ir1), 32'd0);
      tick();
    end
    chk123("t5 hold end", 1, 1'b0);
    rdy = 1'b1;
    tick();
    chk123("t5 f2", 2, 1'b0);
    tick();
    chk123("t5 f3", 3, 1'b1);
    tick();
    chk("t5 idle", 32'(ov1), 32'd0);

    // Test 6: reset while out_index==2, then restart
    iv = 1'b1;
    tick();
    iv = 1'b0;
    tick();
    tick();
    chk("t6 pre index", 32'(oi1), 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6 valid", 32'(ov1), 32'd0);
    chk("t6 ready", 32'(ir1), 32'd1);
    chk("t6 index", 32'(oi1), 32'd0);
    tick();
    chk("t6 no partial", 32'(ov1), 32'd0);
    iv = 1'b1;
    tick();
    iv = 1'b0;
    chk123("t6 restart", 0, 1'b0);
    repeat (4) tick();
    chk("t6 drained", 32'(ov1), 32'd0);

    // Test 4: back-to-back words on [11:4], SLICE=4
    iv4 = 1'b1; rdy4 = 1'b1; d4 = 8'h5A;
    tick();
    d4 = 8'hC3;
    chk("t4 w0f0 data",  32'(od4), 32'hA);
    chk("t4 w0f0 index", 32'(oi4), 32'd0);
    chk("t4 w0f0 ready", 32'(ir4), 32'd0);
    tick();
    iv4 = 1'b0;
    chk("t4 w0f1 data",  32'(od4), 32'h5);
    chk("t4 w0f1 last",  32'(ol4), 32'd1);
    chk("t4 w0f1 ready", 32'(ir4), 32'd1);
    iv4 = 1'b1;
    tick();
    iv4 = 1'b0;
    chk("t4 w1f0 valid", 32'(ov4), 32'd1);
    chk("t4 w1f0 data",  32'(od4), 32'h3);
    chk("t4 w1f0 index", 32'(oi4), 32'd0);
    tick();
    chk("t4 w1f1 data",  32'(od4), 32'hC);
    chk("t4 w1f1 last",  32'(ol4), 32'd1);
    tick();
    chk("t4 idle", 32'(ov4), 32'd0);

    // Single-fragment word: every fragment last, in_ready follows out_ready
    iv5 = 1'b1; rdy5 = 1'b1; d5 = 4'h9;
    tick();
    d5 = 4'h6;
    chk("n1 data0",  32'(od5), 32'h9);
    chk("n1 last0",  32'(ol5), 32'd1);
    chk("n1 ready0", 32'(ir5), 32'd1);
    tick();
    iv5 = 1'b0;
    chk("n1 data1", 32'(od5), 32'h6);
    rdy5 = 1'b0;
    #1;
    chk("n1 ready stall", 32'(ir5), 32'd0);
    chk("n1 valid stall", 32'(ov5), 32'd1);
    tick();
    chk("n1 held", 32'(od5), 32'h6);
    rdy5 = 1'b1;
    tick();
    chk("n1 idle", 32'(ov5), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
